// File: rtl/kv_cache_store.sv
// Key-addressed cache store: parallel key lookup, lowest-free-slot insert, DEL, per-entry TTL expiry.
// Latency: request accepted in IDLE, op applied in EXEC, response presented from RESP (one op per 3 cycles).
// Backpressure: req_ready low outside IDLE; rsp_* held stable in RESP until rsp_ready is seen.
module kv_cache_store #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    input  logic [TTL_WIDTH-1:0]   req_ttl,
    input  logic                   tick,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic                   rsp_err,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic [TTL_WIDTH-1:0]   rsp_ttl,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   full
);

    localparam logic [1:0] OP_GET = 2'b00;
    localparam logic [1:0] OP_PUT = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic [TTL_WIDTH-1:0]   rsp_ttl_q, rsp_ttl_d;

    logic [1:0]             op_code_q, op_code_d;
    logic [KEY_WIDTH-1:0]   op_key_q, op_key_d;
    logic [VALUE_WIDTH-1:0] op_value_q, op_value_d;
    logic [TTL_WIDTH-1:0]   op_ttl_q, op_ttl_d;

    logic [NUM_ENTRIES-1:0] ent_vld_q, ent_vld_d;
    logic [KEY_WIDTH-1:0]   ent_key_q   [NUM_ENTRIES];
    logic [KEY_WIDTH-1:0]   ent_key_d   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] ent_value_q [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] ent_value_d [NUM_ENTRIES];
    logic [TTL_WIDTH-1:0]   ent_ttl_q   [NUM_ENTRIES];
    logic [TTL_WIDTH-1:0]   ent_ttl_d   [NUM_ENTRIES];
    logic [ADDR_WIDTH:0]    count_q, count_d;

    logic                   hit_any;
    logic [ADDR_WIDTH-1:0]  hit_idx;
    logic                   free_any;
    logic [ADDR_WIDTH-1:0]  free_idx;
    logic                   full_w;

    assign full_w    = (count_q == (ADDR_WIDTH+1)'(NUM_ENTRIES));
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_value = rsp_value_q;
    assign rsp_ttl   = rsp_ttl_q;
    assign count     = count_q;
    assign full      = full_w;

    // Parallel key match and lowest-index free slot, both on start-of-cycle state.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_vld_q[i]) begin
                free_any = 1'b1;
                free_idx = ADDR_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_vld_q[i] && (ent_key_q[i] == op_key_q)) begin
                hit_any = 1'b1;
                hit_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Next state: TTL ageing first, then the EXEC op overrides it for the slot it touches.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_err_d   = rsp_err_q;
        rsp_value_d = rsp_value_q;
        rsp_ttl_d   = rsp_ttl_q;
        op_code_d   = op_code_q;
        op_key_d    = op_key_q;
        op_value_d  = op_value_q;
        op_ttl_d    = op_ttl_q;
        ent_vld_d   = ent_vld_q;
        ent_key_d   = ent_key_q;
        ent_value_d = ent_value_q;
        ent_ttl_d   = ent_ttl_q;
        count_d     = '0;

        // Ageing runs in every state; TTL 0 means persistent.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (tick && ent_vld_q[i]) begin
                if (ent_ttl_q[i] == TTL_WIDTH'(1)) begin
                    ent_vld_d[i] = 1'b0;
                end else if (ent_ttl_q[i] > TTL_WIDTH'(1)) begin
                    ent_ttl_d[i] = ent_ttl_q[i] - TTL_WIDTH'(1);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_code_d   = req_op;
                    op_key_d    = req_key;
                    op_value_d  = req_value;
                    op_ttl_d    = req_ttl;
                    req_ready_d = 1'b0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_hit_d   = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_value_d = '0;
                rsp_ttl_d   = '0;
                case (op_code_q)
                    OP_GET: begin
                        // Reads pre-tick contents, so an entry expiring this cycle still hits.
                        if (hit_any) begin
                            rsp_hit_d   = 1'b1;
                            rsp_value_d = ent_value_q[hit_idx];
                            rsp_ttl_d   = ent_ttl_q[hit_idx];
                        end
                    end
                    OP_PUT: begin
                        if (hit_any) begin
                            // Overwrite beats a same-cycle expiry and loads the TTL undecremented.
                            rsp_hit_d              = 1'b1;
                            ent_vld_d[hit_idx]     = 1'b1;
                            ent_value_d[hit_idx]   = op_value_q;
                            ent_ttl_d[hit_idx]     = op_ttl_q;
                        end else if (full_w) begin
                            rsp_err_d = 1'b1;
                        end else if (free_any) begin
                            ent_vld_d[free_idx]    = 1'b1;
                            ent_key_d[free_idx]    = op_key_q;
                            ent_value_d[free_idx]  = op_value_q;
                            ent_ttl_d[free_idx]    = op_ttl_q;
                        end
                    end
                    OP_DEL: begin
                        if (hit_any) begin
                            rsp_hit_d          = 1'b1;
                            ent_vld_d[hit_idx] = 1'b0;
                        end
                    end
                    default: begin
                        rsp_err_d = 1'b1;
                    end
                endcase
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Count follows the final valid bits so expiry and insert in one cycle cancel.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            count_d = count_d + (ADDR_WIDTH+1)'(ent_vld_d[i]);
        end
    end

    // FSM, response registers and entry storage; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_value_q <= '0;
            rsp_ttl_q   <= '0;
            op_code_q   <= '0;
            op_key_q    <= '0;
            op_value_q  <= '0;
            op_ttl_q    <= '0;
            ent_vld_q   <= '0;
            count_q     <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_key_q[i]   <= '0;
                ent_value_q[i] <= '0;
                ent_ttl_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_err_q   <= rsp_err_d;
            rsp_value_q <= rsp_value_d;
            rsp_ttl_q   <= rsp_ttl_d;
            op_code_q   <= op_code_d;
            op_key_q    <= op_key_d;
            op_value_q  <= op_value_d;
            op_ttl_q    <= op_ttl_d;
            ent_vld_q   <= ent_vld_d;
            count_q     <= count_d;
            ent_key_q   <= ent_key_d;
            ent_value_q <= ent_value_d;
            ent_ttl_q   <= ent_ttl_d;
        end
    end

endmodule

// File: tb/tb_kv_cache_store.sv
// Bench for kv_cache_store: key->entry map reference model, response scoreboard, directed and random ops.
// Latency: responses are matched in order, whatever the cycle count.
// Backpressure: rsp_ready and tick are either forced by the directed sequence or randomised.
module tb_kv_cache_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_key;
    logic [63:0] req_value;
    logic [31:0] req_ttl;
    logic        tick;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_err;
    logic [63:0] rsp_value;
    logic [31:0] rsp_ttl;
    logic [4:0]  count;
    logic        full;

    kv_cache_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_value (req_value),
        .req_ttl   (req_ttl),
        .tick      (tick),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_err   (rsp_err),
        .rsp_value (rsp_value),
        .rsp_ttl   (rsp_ttl),
        .count     (count),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] v;
        logic [31:0] t;
    } ent_t;

    typedef struct packed {
        logic        hit;
        logic        err;
        logic [63:0] v;
        logic [31:0] t;
    } rsp_t;

    ent_t        m [logic [63:0]];
    rsp_t        exp_q [$];
    int          errs = 0;
    int          checks = 0;
    int          n_issued = 0;
    int          n_rsp = 0;
    logic        tick_rand = 1'b0, tick_force = 1'b0;
    logic        rsp_rand = 1'b0, rsp_force = 1'b1;
    rsp_t        last_rsp;

    logic        pend = 1'b0;
    logic [1:0]  p_op;
    logic [63:0] p_key, p_val;
    logic [31:0] p_ttl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_tick();
        logic [63:0] k;
        logic [63:0] dq [$];
        if (m.first(k)) begin
            do begin
                if (m[k].t == 32'd1) dq.push_back(k);
                else if (m[k].t > 32'd1) m[k].t = m[k].t - 32'd1;
            end while (m.next(k));
        end
        foreach (dq[j]) m.delete(dq[j]);
    endfunction

    // Tick and rsp_ready drivers, updated just after each rising edge.
    initial begin
        tick = 1'b0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick      = tick_rand ? ($urandom_range(0, 3) == 0) : tick_force;
            rsp_ready = rsp_rand ? ($urandom_range(0, 2) != 0) : rsp_force;
        end
    end

    // Reference model: advanced once per cycle with the inputs the next rising edge will see.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            m.delete();
            exp_q.delete();
            pend = 1'b0;
        end else begin
            chk("count", 64'(count), 64'(m.num()));
            chk("full", 64'(full), 64'(m.num() == 16));
            if (pend) begin
                e = '0;
                case (p_op)
                    2'b00: if (m.exists(p_key)) begin
                        e.hit = 1'b1; e.v = m[p_key].v; e.t = m[p_key].t;
                    end
                    2'b01: begin
                        if (m.exists(p_key)) e.hit = 1'b1;
                        else if (m.num() == 16) e.err = 1'b1;
                    end
                    2'b10: e.hit = m.exists(p_key);
                    default: e.err = 1'b1;
                endcase
                exp_q.push_back(e);
                if (tick) model_tick();
                if (p_op == 2'b01 && !e.err) m[p_key] = '{v: p_val, t: p_ttl};
                if (p_op == 2'b10) m.delete(p_key);
            end else if (tick) begin
                model_tick();
            end
            pend = req_valid && req_ready;
            if (pend) begin
                p_op = req_op; p_key = req_key; p_val = req_value; p_ttl = req_ttl;
            end
        end
    end

    // Scoreboard monitor: one comparison set per response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            last_rsp = '{hit: rsp_hit, err: rsp_err, v: rsp_value, t: rsp_ttl};
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_value", rsp_value, e.v);
                chk("rsp_ttl", 64'(rsp_ttl), 64'(e.t));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [63:0] key,
                         input logic [63:0] val, input logic [31:0] ttl);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = op; req_key = key; req_value = val; req_ttl = ttl;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("req_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ok) n_issued++;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (n_rsp >= n_issued) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("rsp_timeout", 64'(n_rsp), 64'(n_issued));
    endtask

    task automatic op(input logic [1:0] o, input logic [63:0] key,
                      input logic [63:0] val, input logic [31:0] ttl);
        issue(o, key, val, ttl);
        wait_done();
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        tick_force = 1'b1;
        @(posedge clk);
        tick_force = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_rsp = n_issued;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        errs++;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        rsp_t snap;
        bit   seen;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_key = '0; req_value = '0; req_ttl = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_hit", 64'(rsp_hit), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_rsp_value", rsp_value, 64'(0));
        chk("reset_rsp_ttl", 64'(rsp_ttl), 64'(0));
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_full", 64'(full), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Persistent PUT then GET.
        op(2'b01, 64'hA, 64'h11, 32'd0);
        op(2'b00, 64'hA, 64'h0, 32'd0);
        chk("t1_hit", 64'(last_rsp.hit), 64'(1));
        chk("t1_value", last_rsp.v, 64'h11);
        chk("t1_ttl", 64'(last_rsp.t), 64'(0));
        chk("t1_count", 64'(count), 64'(1));

        // TTL ageing and expiry.
        op(2'b01, 64'hB, 64'h22, 32'd3);
        pulse_tick();
        pulse_tick();
        op(2'b00, 64'hB, 64'h0, 32'd0);
        chk("t2_hit", 64'(last_rsp.hit), 64'(1));
        chk("t2_ttl", 64'(last_rsp.t), 64'(1));
        pulse_tick();
        op(2'b00, 64'hB, 64'h0, 32'd0);
        chk("t2_expired_hit", 64'(last_rsp.hit), 64'(0));
        chk("t2_count", 64'(count), 64'(1));

        // Fill to capacity, overflow, overwrite.
        do_reset();
        for (int i = 0; i < 16; i++) op(2'b01, 64'h100 + 64'(i), 64'(i), 32'd0);
        chk("t3_full", 64'(full), 64'(1));
        op(2'b01, 64'h200, 64'h99, 32'd0);
        chk("t3_err", 64'(last_rsp.err), 64'(1));
        chk("t3_count", 64'(count), 64'(16));
        op(2'b01, 64'h105, 64'h55, 32'd0);
        chk("t3_ow_hit", 64'(last_rsp.hit), 64'(1));
        op(2'b00, 64'h105, 64'h0, 32'd0);
        chk("t3_ow_value", last_rsp.v, 64'h55);

        // Delete then reinsert into the freed slot.
        op(2'b10, 64'h103, 64'h0, 32'd0);
        chk("t4_del_hit", 64'(last_rsp.hit), 64'(1));
        chk("t4_not_full", 64'(full), 64'(0));
        op(2'b01, 64'h300, 64'h77, 32'd0);
        chk("t4_put_hit", 64'(last_rsp.hit), 64'(0));
        chk("t4_full", 64'(full), 64'(1));
        op(2'b11, 64'h300, 64'h0, 32'd0);
        chk("t4_reserved_err", 64'(last_rsp.err), 64'(1));

        // Response backpressure: outputs hold while rsp_ready is low.
        rsp_force = 1'b0;
        repeat (2) @(posedge clk);
        issue(2'b00, 64'h300, 64'h0, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk("t5_rsp_seen", 64'(seen), 64'(1));
        snap = '{hit: rsp_hit, err: rsp_err, v: rsp_value, t: rsp_ttl};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(rsp_valid), 64'(1));
            chk("t5_hold_req_ready", 64'(req_ready), 64'(0));
            chk("t5_hold_rsp", 64'({rsp_hit, rsp_err, rsp_value ^ snap.v, rsp_ttl ^ snap.t}),
                64'({snap.hit, snap.err, 64'h0, 32'h0}));
        end
        rsp_force = 1'b1;
        wait_done();
        @(negedge clk);
        chk("t5_after_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("t5_after_req_ready", 64'(req_ready), 64'(1));
        chk("t5_value", last_rsp.v, 64'h77);

        // Reset while a PUT is executing.
        do_reset();
        issue(2'b01, 64'h777, 64'h1234, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_rsp = n_issued;
        @(negedge clk);
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
        op(2'b00, 64'h777, 64'h0, 32'd0);
        chk("t6_get_hit", 64'(last_rsp.hit), 64'(0));

        // Randomised traffic with random ticks and response backpressure.
        tick_rand = 1'b1;
        rsp_rand  = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0] o;
            r = int'($urandom_range(0, 15));
            o = (r < 6) ? 2'b00 : (r < 12) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            issue(o, 64'($urandom_range(0, 23)), {32'($urandom), 32'($urandom)},
                  32'($urandom_range(0, 6)));
        end
        tick_rand = 1'b0;
        rsp_rand  = 1'b0;
        rsp_force = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
